round_robin_arbiter: RTL and testbench

//   Shares one downstream resource between REQUESTERS requesters with rotating priority.

---
 rtl/round_robin_arbiter_pkg.sv | 8 +
 rtl/round_robin_arbiter_onehot_to_binary.sv | 16 +
 rtl/round_robin_arbiter.sv | 81 ++++++++
 tb/tb_round_robin_arbiter.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/round_robin_arbiter_pkg.sv
// round_robin_arbiter_pkg: shared state encoding and sizing helpers for the round-robin arbiter
package round_robin_arbiter_pkg;
  typedef enum logic {IDLE = 1'b0, GRANTED = 1'b1} state_t;
  localparam int DEFAULT_REQUESTERS = 4;
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/round_robin_arbiter_onehot_to_binary.sv
// onehot_to_binary: encodes a zero-hot or one-hot vector into the index of its set bit (0 when none)
module onehot_to_binary
  import round_robin_arbiter_pkg::*;
#(
  parameter int WIDTH_ONEHOT = 4,
  parameter int WIDTH_BINARY = clog2_min1(WIDTH_ONEHOT)
) (
  input  logic [WIDTH_ONEHOT-1:0] i_onehot,
  output logic [WIDTH_BINARY-1:0] o_binary
);
  always_comb begin
    o_binary = '0;
    for (int i = 0; i < WIDTH_ONEHOT; i++)
      o_binary = o_binary | (i_onehot[i] ? WIDTH_BINARY'(i) : '0);
  end
endmodule

// File: rtl/round_robin_arbiter.sv
// round_robin_arbiter: rotating-priority arbiter with registered one-hot/index grant under valid/ready; ROUND_ROBIN_ARBITER_LOCK_EN adds the lock input
module round_robin_arbiter
  import round_robin_arbiter_pkg::*;
#(
  parameter int REQUESTERS  = DEFAULT_REQUESTERS,
  parameter int INDEX_WIDTH = clog2_min1(REQUESTERS)
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic [REQUESTERS-1:0]  requests,
  output logic [REQUESTERS-1:0]  grant_onehot,
  output logic [INDEX_WIDTH-1:0] grant_index,
  output logic                   grant_valid,
  input  logic                   grant_ready
`ifdef ROUND_ROBIN_ARBITER_LOCK_EN
  ,
  input  logic                   lock
`endif
);
  state_t                 r_state, w_state_nxt;
  logic [REQUESTERS-1:0]  r_onehot, w_onehot_nxt, w_pick_req, w_rot, w_pick_onehot;
  logic [INDEX_WIDTH-1:0] r_ptr, w_ptr_nxt, w_index, w_ptr_inc, w_pick_ptr, w_off, w_pick_idx;
  logic [INDEX_WIDTH:0]   w_sum;
  logic                   w_hold;

  onehot_to_binary #(.WIDTH_ONEHOT(REQUESTERS), .WIDTH_BINARY(INDEX_WIDTH)) u_enc (
    .i_onehot (r_onehot),
    .o_binary (w_index)
  );

`ifdef ROUND_ROBIN_ARBITER_LOCK_EN
  assign w_hold = lock & (|(requests & r_onehot));
`else
  assign w_hold = 1'b0;
`endif

  // While granted, the search excludes the current winner and starts just above it
  assign w_ptr_inc  = (w_index == INDEX_WIDTH'(REQUESTERS - 1)) ? '0 : w_index + INDEX_WIDTH'(1);
  assign w_pick_req = (r_state == GRANTED) ? (requests & ~r_onehot) : requests;
  assign w_pick_ptr = (r_state == GRANTED) ? w_ptr_inc : r_ptr;
  assign w_rot      = REQUESTERS'({w_pick_req, w_pick_req} >> w_pick_ptr);

  always_comb begin
    w_off = '0;
    for (int i = REQUESTERS - 1; i >= 0; i--)
      w_off = w_rot[i] ? INDEX_WIDTH'(i) : w_off;
    w_sum         = {1'b0, w_pick_ptr} + {1'b0, w_off};
    w_pick_idx    = (w_sum >= (INDEX_WIDTH + 1)'(REQUESTERS)) ? INDEX_WIDTH'(w_sum - (INDEX_WIDTH + 1)'(REQUESTERS)) : INDEX_WIDTH'(w_sum);
    w_pick_onehot = REQUESTERS'(1) << w_pick_idx;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_onehot_nxt = r_onehot;
    w_ptr_nxt    = r_ptr;
    if (r_state == IDLE) begin
      w_state_nxt  = (|w_pick_req) ? GRANTED : IDLE;
      w_onehot_nxt = (|w_pick_req) ? w_pick_onehot : '0;
    end else if (grant_ready && !w_hold) begin
      w_ptr_nxt    = w_ptr_inc;
      w_state_nxt  = (|w_pick_req) ? GRANTED : IDLE;
      w_onehot_nxt = (|w_pick_req) ? w_pick_onehot : '0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state  <= IDLE;
      r_onehot <= '0;
      r_ptr    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_onehot <= w_onehot_nxt;
      r_ptr    <= w_ptr_nxt;
    end
  end

  assign grant_onehot = r_onehot;
  assign grant_index  = w_index;
  assign grant_valid  = (r_state == GRANTED);
endmodule

// File: tb/tb_round_robin_arbiter.sv
// tb_round_robin_arbiter: randomized and directed scoreboard bench against a rule-level round-robin model
module tb_round_robin_arbiter;
  localparam int N = 4;
`ifdef ROUND_ROBIN_ARBITER_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       resetn = 1'b1;
  logic       grant_ready = 1'b0;
  logic       lock = 1'b0;
  logic [3:0] requests = '0;
  logic [3:0] grant_onehot;
  logic [1:0] grant_index;
  logic       grant_valid;

  always #5 clock = ~clock;

  round_robin_arbiter #(.REQUESTERS(N)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .requests     (requests),
    .grant_onehot (grant_onehot),
    .grant_index  (grant_index),
    .grant_valid  (grant_valid),
    .grant_ready  (grant_ready)
`ifdef ROUND_ROBIN_ARBITER_LOCK_EN
    ,
    .lock         (lock)
`endif
  );

  typedef struct {
    bit v;
    int idx;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  bit   m_valid = 1'b0;
  int   m_idx = 0;
  int   m_ptr = 0;

  function automatic int first_from(input logic [3:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_idx   = 0;
    m_ptr   = 0;
  endtask

  task automatic cycle(input logic [3:0] req, input bit rdy, input bit lk, input bit rst_n);
    logic [3:0] rest;
    bit keep;
    @(negedge clock);
    requests    = req;
    grant_ready = rdy;
    lock        = lk;
    resetn      = rst_n;
    if (!rst_n) model_reset();
    else if (!m_valid) begin
      if (req != 0) begin
        m_idx   = first_from(req, m_ptr);
        m_valid = 1'b1;
      end
    end else if (rdy) begin
      keep = LOCK && lk && req[m_idx];
      if (!keep) begin
        rest = req;
        rest[m_idx] = 1'b0;
        m_ptr = (m_idx + 1) % N;
        if (rest != 0) m_idx = first_from(rest, m_ptr);
        else m_valid = 1'b0;
      end
    end
    q.push_back('{m_valid, m_valid ? m_idx : 0});
  endtask

  task automatic assert_reset_check(input string name);
    resetn = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({grant_valid, grant_onehot, grant_index} != 7'd0) begin
      failures++;
      $display("FAIL %s: got v=%0b oh=%b idx=%0d want all zero", name, grant_valid, grant_onehot, grant_index);
    end
  endtask

  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (q.size() != 0) begin
        exp_t e;
        logic [3:0] eoh;
        e = q.pop_front();
        eoh = e.v ? 4'(1 << e.idx) : 4'd0;
        checks++;
        if ({grant_valid, grant_onehot, grant_index} != {e.v, eoh, 2'(e.idx)}) begin
          failures++;
          $display("FAIL grant @%0t: got v=%0b oh=%b idx=%0d want v=%0b oh=%b idx=%0d",
                   $time, grant_valid, grant_onehot, grant_index, e.v, eoh, e.idx);
        end
      end
    end
  end

  initial begin
    #2;
    assert_reset_check("reset_initial");
    repeat (3) cycle(4'b1111, 1'b0, 1'b0, 1'b0);
    repeat (6) cycle(4'b1111, 1'b1, 1'b0, 1'b1);
    cycle(4'b0000, 1'b0, 1'b0, 1'b0);
    cycle(4'b0100, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cycle(4'($urandom_range(0, 15)), 1'b0, 1'b0, 1'b1);
    cycle(4'b0000, 1'b1, 1'b0, 1'b1);
    cycle(4'b0110, 1'b0, 1'b0, 1'b1);
    cycle(4'b0110, 1'b1, 1'b0, 1'b1);
    cycle(4'b0000, 1'b1, 1'b0, 1'b1);
    cycle(4'b0000, 1'b0, 1'b0, 1'b1);
    cycle(4'b1000, 1'b1, 1'b0, 1'b1);
    cycle(4'b1000, 1'b1, 1'b0, 1'b1);
    cycle(4'b1000, 1'b1, 1'b0, 1'b1);
    if (LOCK) begin
      cycle(4'b0000, 1'b0, 1'b0, 1'b0);
      cycle(4'b1011, 1'b0, 1'b0, 1'b1);
      cycle(4'b1011, 1'b1, 1'b0, 1'b1);
      repeat (3) cycle(4'b1011, 1'b1, 1'b1, 1'b1);
      cycle(4'b1011, 1'b1, 1'b0, 1'b1);
      cycle(4'b1001, 1'b1, 1'b1, 1'b1);
      cycle(4'b0101, 1'b1, 1'b1, 1'b1);
    end
    cycle(4'b1111, 1'b0, 1'b0, 1'b1);
    cycle(4'b1111, 1'b0, 1'b0, 1'b1);
    @(posedge clock);
    #3;
    assert_reset_check("reset_mid_grant");
    cycle(4'b1111, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 400; i++)
      cycle(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            LOCK ? 1'($urandom_range(0, 1)) : 1'b0, $urandom_range(0, 63) != 0);
    @(posedge clock);
    #3;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
